ram_arb2: RTL

- Two-requester arbiter sharing the single-port-per-direction sram between the agent-side master (port 0) and a second on-chip master (port 1, e.g. OTP loader/debug path).
- Grants at most one access per cycle, round-robin on contention.
- Drives the sram read/write ports (s_ram_*) and returns read data with 1-cycle latency to the owning requester.
- Sits between masters and the sram instance in top.

---
 rtl/ram_arb2.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ram_arb2.sv
// Two-master round-robin arbiter onto a split read/write sram port; grant is same-cycle, read data returns 1 cycle later.
// Loser waits with req held (no queuing). Optional ownership lock enabled with `define ARB_LOCK_EN.
module ram_arb2 #(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    m0_req,
  input  logic                    m0_we,
  input  logic [BUS_WIDTH-1:0]    m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
  input  logic                    m0_lock,
  output logic                    m0_gnt,
  output logic                    m0_rvalid,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  input  logic                    m1_req,
  input  logic                    m1_we,
  input  logic [BUS_WIDTH-1:0]    m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
  input  logic                    m1_lock,
  output logic                    m1_gnt,
  output logic                    m1_rvalid,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic [BUS_WIDTH-1:0]    s_ram_raddr,
  output logic                    s_ram_ren,
  output logic [BUS_WIDTH-1:0]    s_ram_waddr,
  output logic [DATA_WIDTH-1:0]   s_ram_wdata,
  output logic [DATA_WIDTH/8-1:0] s_ram_wen,
  input  logic [DATA_WIDTH-1:0]   s_ram_rdata
);

  logic last_owner_q, last_owner_d;
  logic rd_pend_q, rd_pend_d;
  logic rd_owner_q, rd_owner_d;
  logic elig0, elig1;
  logic any_gnt, sel, sel_we;

`ifdef ARB_LOCK_EN
  logic lock_vld_q, lock_vld_d;
  logic lock_owner_q, lock_owner_d;
`else
  logic unused_lock;
  assign unused_lock = m0_lock | m1_lock;
`endif

  always_comb begin
    elig0 = m0_req;
    elig1 = m1_req;
`ifdef ARB_LOCK_EN
    if (lock_vld_q) begin
      elig0 = m0_req && !lock_owner_q;
      elig1 = m1_req && lock_owner_q;
    end
`endif
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    // Grants are forced low while reset is held so nothing reaches the sram.
    if (resetn) begin
      if (elig0 && elig1) begin
        m0_gnt = last_owner_q;
        m1_gnt = !last_owner_q;
      end else begin
        m0_gnt = elig0;
        m1_gnt = elig1;
      end
    end
    any_gnt = m0_gnt | m1_gnt;
    sel     = m1_gnt;
    sel_we  = sel ? m1_we : m0_we;

    s_ram_ren   = 1'b0;
    s_ram_raddr = '0;
    s_ram_wen   = '0;
    s_ram_waddr = '0;
    s_ram_wdata = '0;
    if (any_gnt) begin
      if (sel_we) begin
        s_ram_wen   = sel ? m1_wstrb : m0_wstrb;
        s_ram_waddr = sel ? m1_addr  : m0_addr;
        s_ram_wdata = sel ? m1_wdata : m0_wdata;
      end else begin
        s_ram_ren   = 1'b1;
        s_ram_raddr = sel ? m1_addr : m0_addr;
      end
    end

    last_owner_d = any_gnt ? sel : last_owner_q;
    rd_pend_d    = any_gnt && !sel_we;
    rd_owner_d   = (any_gnt && !sel_we) ? sel : rd_owner_q;
`ifdef ARB_LOCK_EN
    lock_vld_d   = lock_vld_q;
    lock_owner_d = lock_owner_q;
    if (any_gnt) begin
      lock_vld_d   = sel ? m1_lock : m0_lock;
      lock_owner_d = sel;
    end
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_owner_q <= 1'b1;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
    end else begin
      last_owner_q <= last_owner_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

`ifdef ARB_LOCK_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_vld_q   <= 1'b0;
      lock_owner_q <= 1'b0;
    end else begin
      lock_vld_q   <= lock_vld_d;
      lock_owner_q <= lock_owner_d;
    end
  end
`endif

  assign m0_rvalid = rd_pend_q && !rd_owner_q;
  assign m1_rvalid = rd_pend_q && rd_owner_q;
  assign m0_rdata  = m0_rvalid ? s_ram_rdata : '0;
  assign m1_rdata  = m1_rvalid ? s_ram_rdata : '0;

endmodule
